// File: rtl/calculadora_pkg.sv
// calculadora_pkg: shared width, FSM encoding and 7-segment codes for the calculator display path.
`default_nettype none

package calculadora_pkg;

  localparam int LARGURA = 8;

  localparam logic [1:0] OCIOSO   = 2'd0;
  localparam logic [1:0] CONVERTE = 2'd1;
  localparam logic [1:0] ATUALIZA = 2'd2;

  // Active low, bit order g f e d c b a
  localparam logic [6:0] SEG_0       = 7'b1000000;
  localparam logic [6:0] SEG_1       = 7'b1111001;
  localparam logic [6:0] SEG_2       = 7'b0100100;
  localparam logic [6:0] SEG_3       = 7'b0110000;
  localparam logic [6:0] SEG_4       = 7'b0011001;
  localparam logic [6:0] SEG_5       = 7'b0010010;
  localparam logic [6:0] SEG_6       = 7'b0000010;
  localparam logic [6:0] SEG_7       = 7'b1111000;
  localparam logic [6:0] SEG_8       = 7'b0000000;
  localparam logic [6:0] SEG_9       = 7'b0010000;
  localparam logic [6:0] SEG_APAGADO = 7'b1111111;
  localparam logic [6:0] SEG_MENOS   = 7'b0111111;

  function automatic logic [6:0] seg_digito(input logic [3:0] d);
    logic [6:0] s;
    s = SEG_APAGADO;
    case (d)
      4'd0: s = SEG_0;
      4'd1: s = SEG_1;
      4'd2: s = SEG_2;
      4'd3: s = SEG_3;
      4'd4: s = SEG_4;
      4'd5: s = SEG_5;
      4'd6: s = SEG_6;
      4'd7: s = SEG_7;
      4'd8: s = SEG_8;
      4'd9: s = SEG_9;
      default: s = SEG_APAGADO;
    endcase
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/conversor_bcd.sv
// conversor_bcd: sequential double-dabble, one shift-and-add-3 step per clock, eight steps per byte.
`default_nettype none

module conversor_bcd
  import calculadora_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               inicio,
  input  logic [LARGURA-1:0] magnitude,
  output logic               pronto,
  output logic [3:0]         centenas,
  output logic [3:0]         dezenas,
  output logic [3:0]         unidades
);

  logic [19:0] deslocamento;
  logic [19:0] ajustado;
  logic [2:0]  passo;
  logic        ativo;

  always_comb begin
    ajustado = deslocamento;
    if (ajustado[11:8] >= 4'd5)
      ajustado[11:8] = ajustado[11:8] + 4'd3;
    if (ajustado[15:12] >= 4'd5)
      ajustado[15:12] = ajustado[15:12] + 4'd3;
    if (ajustado[19:16] >= 4'd5)
      ajustado[19:16] = ajustado[19:16] + 4'd3;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deslocamento <= '0;
      passo        <= '0;
      ativo        <= 1'b0;
    end else if (inicio) begin
      deslocamento <= {12'd0, magnitude};
      passo        <= '0;
      ativo        <= 1'b1;
    end else if (ativo) begin
      deslocamento <= {ajustado[18:0], 1'b0};
      passo        <= passo + 3'd1;
      if (passo == 3'd7)
        ativo <= 1'b0;
    end
  end

  // High during the final step; the BCD outputs are valid from the following cycle.
  assign pronto   = ativo && (passo == 3'd7);
  assign centenas = deslocamento[19:16];
  assign dezenas  = deslocamento[15:12];
  assign unidades = deslocamento[11:8];

endmodule

`default_nettype wire

// File: rtl/display_calculadora.sv
// display_calculadora: registers the calculator result, converts it to BCD with optional sign
// and scans it onto a 4-digit multiplexed active-low common-anode 7-segment display.
`default_nettype none

module display_calculadora
  import calculadora_pkg::*;
#(
  parameter int DIV_VARREDURA = 1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [LARGURA-1:0] valor,
  input  logic               modo_sinal,
  output logic [6:0]         segmentos,
  output logic [3:0]         anodos,
  output logic               ocupado
);

  localparam int              PW        = (DIV_VARREDURA > 2) ? $clog2(DIV_VARREDURA) : 1;
  localparam logic [PW-1:0]   PRESC_MAX = PW'(DIV_VARREDURA - 1);

  logic [1:0]         estado;
  logic               pendente;
  logic [LARGURA:0]   ultimo;
  logic               neg_conv;
  logic               requisicao;
  logic               inicio;
  logic               negativo;
  logic [LARGURA-1:0] magnitude;
  logic               pronto;
  logic [3:0]         bcd_c, bcd_d, bcd_u;

  logic [3:0]         disp_c, disp_d, disp_u;
  logic               disp_neg;
  logic               disp_valido;

  logic [PW-1:0]      presc;
  logic [1:0]         indice;
  logic [6:0]         seg_atual;

  assign requisicao = pendente || ({modo_sinal, valor} != ultimo);
  assign inicio     = (estado == OCIOSO) && requisicao;
  assign negativo   = modo_sinal && valor[LARGURA-1];
  // Two's complement negate; -128 wraps to 8'h80, which reads as 128 unsigned.
  assign magnitude  = negativo ? (~valor + 8'd1) : valor;

  conversor_bcd u_conversor (
    .clk       (clk),
    .rst       (rst),
    .inicio    (inicio),
    .magnitude (magnitude),
    .pronto    (pronto),
    .centenas  (bcd_c),
    .dezenas   (bcd_d),
    .unidades  (bcd_u)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado      <= OCIOSO;
      pendente    <= 1'b1;
      ultimo      <= '0;
      neg_conv    <= 1'b0;
      ocupado     <= 1'b0;
      disp_c      <= '0;
      disp_d      <= '0;
      disp_u      <= '0;
      disp_neg    <= 1'b0;
      disp_valido <= 1'b0;
    end else begin
      case (estado)
        OCIOSO: begin
          ocupado <= requisicao;
          if (requisicao) begin
            ultimo   <= {modo_sinal, valor};
            pendente <= 1'b0;
            neg_conv <= negativo;
            estado   <= CONVERTE;
          end
        end
        CONVERTE: begin
          ocupado <= 1'b1;
          if (pronto)
            estado <= ATUALIZA;
        end
        ATUALIZA: begin
          ocupado     <= 1'b1;
          disp_c      <= bcd_c;
          disp_d      <= bcd_d;
          disp_u      <= bcd_u;
          disp_neg    <= neg_conv;
          disp_valido <= 1'b1;
          estado      <= OCIOSO;
        end
        default: estado <= OCIOSO;
      endcase
    end
  end

  always_comb begin
    seg_atual = SEG_APAGADO;
    if (disp_valido) begin
      case (indice)
        2'd0: seg_atual = seg_digito(disp_u);
        2'd1: seg_atual = ((disp_c == 4'd0) && (disp_d == 4'd0)) ? SEG_APAGADO : seg_digito(disp_d);
        2'd2: seg_atual = (disp_c == 4'd0) ? SEG_APAGADO : seg_digito(disp_c);
        default: seg_atual = disp_neg ? SEG_MENOS : SEG_APAGADO;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc     <= '0;
      indice    <= '0;
      segmentos <= SEG_APAGADO;
      anodos    <= 4'b1111;
    end else begin
      if (presc == PRESC_MAX) begin
        presc  <= '0;
        indice <= indice + 2'd1;
      end else begin
        presc <= presc + 1'b1;
      end
      segmentos <= seg_atual;
      anodos    <= ~(4'b0001 << indice);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_display_calculadora.sv
// tb_display_calculadora: directed checks of conversion latency, digit content, scan order and reset.
`default_nettype none

module tb_display_calculadora;

  localparam logic [6:0] S_BLANK = 7'b1111111;
  localparam logic [6:0] S_MENOS = 7'b0111111;
  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0010000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] valor = 8'd0;
  logic       modo_sinal = 1'b0;
  logic [6:0] segmentos;
  logic [3:0] anodos;
  logic       ocupado;

  int erros = 0;
  int total = 0;

  display_calculadora #(.DIV_VARREDURA(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .valor      (valor),
    .modo_sinal (modo_sinal),
    .segmentos  (segmentos),
    .anodos     (anodos),
    .ocupado    (ocupado)
  );

  always #5 clk = ~clk;

  task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    total++;
    if (obs !== esp) begin
      erros++;
      $display("FAIL %s: got=%0h expected=%0h", tag, obs, esp);
    end
  endtask

  // Waits for digit d to be lit and returns its segments; all ones (blank) on timeout.
  task automatic le_digito(input int d, output logic [6:0] s, output bit ok);
    logic [3:0] alvo;
    alvo = ~(4'b0001 << d);
    ok = 1'b0;
    s = 7'h7f;
    for (int i = 0; i < 24; i++) begin
      if (anodos == alvo) begin
        ok = 1'b1;
        s = segmentos;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic confere_digitos(input string tag, input logic [6:0] e3, input logic [6:0] e2,
                                 input logic [6:0] e1, input logic [6:0] e0);
    logic [6:0] s;
    bit ok;
    le_digito(0, s, ok); verifica({tag, "_unid"}, {ok, s}, {1'b1, e0});
    le_digito(1, s, ok); verifica({tag, "_dez"},  {ok, s}, {1'b1, e1});
    le_digito(2, s, ok); verifica({tag, "_cent"}, {ok, s}, {1'b1, e2});
    le_digito(3, s, ok); verifica({tag, "_sinal"}, {ok, s}, {1'b1, e3});
  endtask

  task automatic espera_ocupado(input string tag);
    int i;
    i = 0;
    while (!ocupado && i < 6) begin
      @(negedge clk);
      i++;
    end
    verifica({tag, "_sobe"}, 32'(ocupado), 32'd1);
  endtask

  task automatic mede_ocupado(output int n);
    n = 0;
    while (ocupado && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic converte(input string tag, input logic [7:0] v, input logic m,
                          input logic [6:0] e3, input logic [6:0] e2,
                          input logic [6:0] e1, input logic [6:0] e0);
    int n;
    @(negedge clk);
    valor = v;
    modo_sinal = m;
    @(negedge clk);
    espera_ocupado(tag);
    mede_ocupado(n);
    verifica({tag, "_ciclos"}, 32'(n), 32'd10);
    confere_digitos(tag, e3, e2, e1, e0);
  endtask

  initial begin
    int n;
    bit viu42;
    logic [3:0] ant;
    bit sinc;

    repeat (3) @(negedge clk);
    verifica("rst_seg", 32'(segmentos), 32'h7f);
    verifica("rst_an",  32'(anodos),    32'hf);
    verifica("rst_ocup", 32'(ocupado),  32'd0);

    rst = 1'b0;
    @(negedge clk);
    verifica("prim_an",   32'(anodos),  32'he);
    verifica("prim_ocup", 32'(ocupado), 32'd1);
    mede_ocupado(n);
    verifica("prim_ciclos", 32'(n), 32'd10);
    confere_digitos("zero", S_BLANK, S_BLANK, S_BLANK, S0);

    converte("u255", 8'd255, 1'b0, S_BLANK, S2, S5, S5);
    converte("m10",  8'hF6,  1'b1, S_MENOS, S_BLANK, S1, S0);
    converte("m128", 8'h80,  1'b1, S_MENOS, S1, S2, S8);

    // 7 -> 42 -> 99 while busy: one follow-up conversion, 42 never shown.
    @(negedge clk);
    valor = 8'd7;
    modo_sinal = 1'b0;
    @(negedge clk);
    espera_ocupado("seq");
    n = 0;
    viu42 = 1'b0;
    while (ocupado && n < 60) begin
      if (n == 2) valor = 8'd42;
      if (n == 5) valor = 8'd99;
      if (anodos == 4'b1101 && segmentos == S4) viu42 = 1'b1;
      n++;
      @(negedge clk);
    end
    verifica("seq_ciclos", 32'(n), 32'd20);
    for (int i = 0; i < 20; i++) begin
      if (anodos == 4'b1101 && segmentos == S4) viu42 = 1'b1;
      @(negedge clk);
    end
    verifica("seq_sem42", 32'(viu42), 32'd0);
    confere_digitos("seq", S_BLANK, S_BLANK, S9, S9);

    // Scan order with DIV_VARREDURA = 4
    sinc = 1'b0;
    ant = anodos;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ant == 4'b0111 && anodos == 4'b1110) begin
        sinc = 1'b1;
        break;
      end
      ant = anodos;
    end
    verifica("scan_sinc", 32'(sinc), 32'd1);
    for (int k = 0; k < 16; k++) begin
      logic [3:0] esp_an;
      esp_an = ~(4'b0001 << (k / 4));
      verifica($sformatf("scan_%0d", k), 32'(anodos), 32'(esp_an));
      @(negedge clk);
    end

    // Asynchronous reset in the middle of a conversion
    valor = 8'd123;
    @(negedge clk);
    espera_ocupado("abort");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    verifica("abort_seg",  32'(segmentos), 32'h7f);
    verifica("abort_an",   32'(anodos),    32'hf);
    verifica("abort_ocup", 32'(ocupado),   32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    verifica("pos_abort_an", 32'(anodos), 32'he);
    mede_ocupado(n);
    verifica("pos_abort_ciclos", 32'(n), 32'd10);
    confere_digitos("c123", S_BLANK, S1, S2, 7'b0110000);

    $display("Result: errors=%0d of %0d checks", erros, total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/display_calculadora.md
# display_calculadora

Downstream display stage for the 8-bit calculator result. Registers the result word and converts it to three BCD digits with a sequential double-dabble (one bit per clock). Optionally interprets the word as two's complement and adds a minus sign. Drives a 4-digit multiplexed, active-low, common-anode 7-segment display with leading-zero blanking.

## Interface
- `DIV_VARREDURA`, default 1000: clock cycles each digit stays lit; legal range ≥2.
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  reset, asynchronous, active-high.
- `valor`  in  8  result word from the calculator output `saida`.
- `modo_sinal`  in  1  1 = `valor` is two's complement; 0 = unsigned.
- `segmentos`  out  7  segment drive, active low, bit order g f e d c b a (bit6 = g).
- `anodos`  out  4  digit enables, active low, one-hot; bit0 = units, bit3 = sign.
- `ocupado`  out  1  high while a conversion is in progress.

## Operation
- FSM states:
  - OCIOSO: a conversion is requested when `pendente` = 1, or when {`modo_sinal`,`valor`} ≠ `ultimo` (the last converted pair).
    - On request: latch the pair into `ultimo`, clear `pendente`, and load the magnitude. If `modo_sinal` & `valor[7]`, the magnitude is −`valor` (8-bit; −128 gives 128) and the negative flag is set. Otherwise the magnitude is `valor` and the flag is clear.
    - Then go to CONVERTE with counter = 0.
  - CONVERTE: one double-dabble step per clock. Each BCD nibble ≥5 gets +3, then the {BCD, magnitude} register shifts left 1. After the 8th step go to ATUALIZA.
  - ATUALIZA: copy the hundreds/tens/units BCD and the negative flag into the display registers, then return to OCIOSO.
- `pendente` is set by reset, so the first conversion after reset is unconditional.
- Input changes during CONVERTE or ATUALIZA are not sampled. On return to OCIOSO the current input is compared again, so the last value always wins.
- Digit content:
  - Units digit is always shown.
  - Tens digit is blank if hundreds = 0 and tens = 0.
  - Hundreds digit is blank if hundreds = 0.
  - Sign digit shows minus (only g lit) when the negative flag is set; otherwise it is blank.
  - Until the first ATUALIZA, all digits are blank.
- Scan:
  - The prescaler counts 0..`DIV_VARREDURA`−1.
  - On wrap, the digit index advances 0→1→2→3→0.
  - `anodos` = ~(1 << index); `segmentos` = encoding of that digit.
- Segment codes (active low, gfedcba):
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
  - blank = 1111111, minus = 0111111

## Timing
- Reset values: `segmentos` = 7'b1111111, `anodos` = 4'b1111, `ocupado` = 0, FSM = OCIOSO, prescaler = 0, index = 0, display registers blank, `pendente` = 1.
- Reset mid-conversion aborts immediately and returns everything to the reset values.
- `segmentos` and `anodos` are registered. The first edge after reset release drives `anodos` = 4'b1110.
- Latency, edge-by-edge:
  - Edge N: OCIOSO detects a change; `ocupado` rises.
  - Edges N+1..N+8: CONVERTE, one step per edge.
  - Edge N+9: ATUALIZA loads the display registers.
  - Edge N+10: `segmentos` reflects the new value for the lit digit; `ocupado` falls.
- `ocupado` is high for exactly 10 cycles per conversion.
- The digit index changes every `DIV_VARREDURA` cycles. A display register update between wraps takes effect on the next edge, with no additional scan latency.

## Structure
- Package `calculadora_pkg` holds:
  - the segment-code constants (digits 0–9, blank, minus);
  - the FSM state encoding (OCIOSO, CONVERTE, ATUALIZA);
  - the width constant 8 shared with the calculator.
- Sub-module `conversor_bcd` contains the sequential double-dabble:
  - inputs: `inicio`, 8-bit magnitude;
  - outputs: `pronto` and three BCD nibbles.
- `display_calculadora` itself owns:
  - the change detector and the negative-flag logic;
  - the display registers;
  - the prescaler, scan index and segment decode.

## Test plan
- Reset release with `valor` = 0, `modo_sinal` = 0:
  - `anodos` goes 1110 on the first edge;
  - 10 cycles later, units shows 1000000 and the other three digits show blank.
- `valor` = 8'd255, `modo_sinal` = 0 → digits 2/1/0 = 2, 5, 5; sign digit blank; `ocupado` high for exactly 10 cycles.
- `valor` = 8'hF6, `modo_sinal` = 1 → sign digit = minus, tens = 1, units = 0, hundreds blank.
- `valor` = 8'h80, `modo_sinal` = 1 → minus, 1, 2, 8.
- `valor` changed 7 → 42 → 99 while `ocupado` is high:
  - the running conversion completes showing 7;
  - exactly one follow-up conversion then shows 99;
  - 42 is never displayed.
- With `DIV_VARREDURA` = 4, `anodos` cycles 1110 → 1101 → 1011 → 0111, each held 4 cycles. `rst` asserted mid-CONVERTE returns all outputs to their reset values on the same cycle.
